// File: rtl/hilo_unit_if.sv
// Bus between the CPU pipeline and the HI/LO register unit: arithmetic result capture,
// move-to/move-from requests, and the stall/status outputs back to the pipeline.
interface hilo_unit_if;
   logic        arith_start;
   logic        arith_valid;
   logic [63:0] arith_result;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        mfhi;
   logic        mflo;
   logic [31:0] rdata;
   logic        stall;
   logic        busy;
   logic        timeout;
   logic        hilo_zero;

   modport master (
      output arith_start, arith_valid, arith_result, mthi, mtlo, wdata, mfhi, mflo,
      input  rdata, stall, busy, timeout, hilo_zero
   );

   modport slave (
      input  arith_start, arith_valid, arith_result, mthi, mtlo, wdata, mfhi, mflo,
      output rdata, stall, busy, timeout, hilo_zero
   );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO registers behind the multiplier/divider; results land one cycle after arith_valid.
// Any HI/LO access stalls while a multiply/divide is pending; a watchdog ends PEND after MAX_WAIT cycles.
module hilo_unit #(
   parameter int MAX_WAIT = 64
) (
   input  logic       clk,
   input  logic       reset,
   hilo_unit_if.slave bus
);

   localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

   typedef enum logic {IDLE, PEND} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   hi, hi_n;
   logic [31:0]   lo, lo_n;
   logic          busy_q;
   logic          timeout_q, timeout_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hi        <= hi_n;
         lo        <= lo_n;
         busy_q    <= (state_n == PEND);
         timeout_q <= timeout_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      hi_n      = hi;
      lo_n      = lo;
      timeout_n = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mthi) hi_n = bus.wdata;
            if (bus.mtlo) lo_n = bus.wdata;
            if (bus.arith_start) begin
               state_n = PEND;
               cnt_n   = '0;
            end
         end
         PEND: begin
            // A result arriving on the last watchdog cycle beats the timeout.
            if (bus.arith_valid) begin
               hi_n    = bus.arith_result[63:32];
               lo_n    = bus.arith_result[31:0];
               state_n = IDLE;
            end else if (cnt == LAST) begin
               state_n   = IDLE;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // No bypass: reads always see the registered HI/LO.
   assign bus.rdata     = bus.mfhi ? hi : (bus.mflo ? lo : 32'h0);
   assign bus.stall     = (state == PEND) &
                          (bus.arith_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo);
   assign bus.busy      = busy_q;
   assign bus.timeout   = timeout_q;
   assign bus.hilo_zero = ({hi, lo} == 64'h0);

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a cycle-level reference model and literal spot checks.
module tb_hilo_unit;
   localparam int MAXW = 4;

   logic clk;
   logic reset;
   hilo_unit_if bus ();

   hilo_unit #(.MAX_WAIT(MAXW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending op tracked by its issue cycle and a deadline.
   logic [31:0] m_hi, m_lo;
   bit          m_pend, m_to;
   int          cyc, m_start;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi = 0; m_lo = 0; m_pend = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (!m_pend) begin
            if (bus.mthi) m_hi = bus.wdata;
            if (bus.mtlo) m_lo = bus.wdata;
            if (bus.arith_start) begin
               m_pend  = 1;
               m_start = cyc;
            end
         end else if (bus.arith_valid) begin
            {m_hi, m_lo} = bus.arith_result;
            m_pend = 0;
         end else if (cyc - m_start == MAXW) begin
            m_pend = 0;
            m_to   = 1;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [31:0] exp_rd;
         exp_rd = bus.mfhi ? m_hi : (bus.mflo ? m_lo : 32'h0);
         check("rdata", 64'(bus.rdata), 64'(exp_rd));
         check("stall", 64'(bus.stall),
               64'(m_pend & (bus.arith_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo)));
         check("busy", 64'(bus.busy), 64'(m_pend));
         check("timeout", 64'(bus.timeout), 64'(m_to));
         check("hilo_zero", 64'(bus.hilo_zero), 64'({m_hi, m_lo} == 64'h0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc = 0; m_start = 0;
      reset = 1'b0;
      bus.arith_start = 0; bus.arith_valid = 0; bus.arith_result = '0;
      bus.mthi = 0; bus.mtlo = 0; bus.wdata = '0; bus.mfhi = 0; bus.mflo = 0;
      repeat (2) tick();
      reset = 1'b1;
      cmp_en = 1'b1;
      #1;
      check("rst_rdata", 64'(bus.rdata), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_timeout", 64'(bus.timeout), 64'h0);
      check("rst_zero", 64'(bus.hilo_zero), 64'h1);

      // Multiply: start at S, valid at S+3.
      tick(); bus.arith_start = 1;
      tick(); bus.arith_start = 0; #1; check("a_busy1", 64'(bus.busy), 64'h1);
      tick(); bus.mflo = 1; #1; check("a_stall", 64'(bus.stall), 64'h1);
      tick(); bus.arith_valid = 1; bus.arith_result = 64'hFFFFFFFF_FFFFFFF1;
      #1; check("a_busy3", 64'(bus.busy), 64'h1); check("a_stall_v", 64'(bus.stall), 64'h1);
      tick(); bus.arith_valid = 0; #1;
      check("a_busy4", 64'(bus.busy), 64'h0);
      check("a_lo", 64'(bus.rdata), 64'hFFFFFFF1);
      check("a_nostall", 64'(bus.stall), 64'h0);
      bus.mfhi = 1; #1; check("a_hi", 64'(bus.rdata), 64'hFFFFFFFF);
      bus.mfhi = 0; bus.mflo = 0;

      // Watchdog expiry with a stray valid afterwards.
      tick(); bus.arith_start = 1;
      tick(); bus.arith_start = 0;
      repeat (3) begin
         tick(); #1; check("b_busy", 64'(bus.busy), 64'h1); check("b_to0", 64'(bus.timeout), 64'h0);
      end
      tick(); bus.mfhi = 1; #1;
      check("b_timeout", 64'(bus.timeout), 64'h1);
      check("b_busy_lo", 64'(bus.busy), 64'h0);
      check("b_hi_kept", 64'(bus.rdata), 64'hFFFFFFFF);
      tick(); bus.mfhi = 0; bus.arith_valid = 1; bus.arith_result = 64'h11111111_22222222;
      #1; check("b_to_once", 64'(bus.timeout), 64'h0);
      tick(); bus.arith_valid = 0; bus.mflo = 1; #1;
      check("b_stray", 64'(bus.rdata), 64'hFFFFFFF1);
      bus.mflo = 0;

      // Valid on the final watchdog cycle wins.
      tick(); bus.arith_start = 1;
      tick(); bus.arith_start = 0;
      repeat (2) tick();
      tick(); bus.arith_valid = 1; bus.arith_result = 64'h00000002_00000003;
      tick(); bus.arith_valid = 0; bus.mfhi = 1; #1;
      check("c_to", 64'(bus.timeout), 64'h0);
      check("c_busy", 64'(bus.busy), 64'h0);
      check("c_hi", 64'(bus.rdata), 64'h2);

      // Moves in IDLE, no bypass.
      tick(); bus.mthi = 1; bus.wdata = 32'h12345678; #1;
      check("d_oldhi", 64'(bus.rdata), 64'h2);
      tick(); bus.mthi = 0; #1; check("d_newhi", 64'(bus.rdata), 64'h12345678);
      check("d_nz", 64'(bus.hilo_zero), 64'h0);
      bus.mfhi = 0;
      tick(); bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h0;
      tick(); bus.mthi = 0; bus.mtlo = 0; #1; check("d_zero", 64'(bus.hilo_zero), 64'h1);

      // Moves and reads held under stall in PEND.
      tick(); bus.arith_start = 1;
      tick(); bus.arith_start = 0; bus.mthi = 1; bus.wdata = 32'hAAAA5555; bus.mfhi = 1; bus.mflo = 1;
      #1; check("e_stall", 64'(bus.stall), 64'h1); check("e_hi", 64'(bus.rdata), 64'h0);
      tick(); bus.arith_valid = 1; bus.arith_result = 64'h0000000A_0000000B;
      #1; check("e_stall_v", 64'(bus.stall), 64'h1);
      tick(); bus.arith_valid = 0; #1;
      check("e_busy", 64'(bus.busy), 64'h0);
      check("e_nostall", 64'(bus.stall), 64'h0);
      check("e_res_hi", 64'(bus.rdata), 64'hA);
      tick(); bus.mthi = 0; bus.mflo = 0; #1; check("e_mthi", 64'(bus.rdata), 64'hAAAA5555);
      bus.mfhi = 0; bus.mflo = 1; #1; check("e_lo", 64'(bus.rdata), 64'hB);
      bus.mflo = 0;

      // Back-to-back: new start in the cycle busy falls.
      tick(); bus.arith_start = 1;
      tick(); bus.arith_start = 0; bus.arith_valid = 1; bus.arith_result = 64'h00000005_00000006;
      tick(); bus.arith_valid = 0; bus.arith_start = 1; #1; check("f_busy0", 64'(bus.busy), 64'h0);
      tick(); bus.arith_start = 0; #1; check("f_busy1", 64'(bus.busy), 64'h1);
      bus.arith_valid = 1; bus.arith_result = 64'h00000007_00000008;
      tick(); bus.arith_valid = 0;

      // Asynchronous reset in the middle of PEND.
      tick(); bus.arith_start = 1;
      tick(); bus.arith_start = 0; bus.mfhi = 1; #1;
      check("g_pre_hi", 64'(bus.rdata), 64'h7);
      check("g_pre_busy", 64'(bus.busy), 64'h1);
      reset = 1'b0; #1;
      check("g_rdata", 64'(bus.rdata), 64'h0);
      check("g_busy", 64'(bus.busy), 64'h0);
      check("g_zero", 64'(bus.hilo_zero), 64'h1);
      check("g_stall", 64'(bus.stall), 64'h0);
      tick(); reset = 1'b1; bus.mfhi = 0;
      repeat (8) tick();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
